// File: rtl/fft_pingpong_ram_if.sv
// Purpose : producer-side and engine-side signal bundle for the ping-pong sample buffer.
// Latency : none, wiring only.
// Backpressure: producer is stalled by wr_ready; engine accesses are only honoured while frame_ready.
// Modports: master = producer/engine side, slave = buffer side.
interface fft_pingpong_ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
) ();
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_byteenable;
    logic                  frame_ready;
    logic                  rd_bank;
    logic [ADDR_W-1:0]     rd_address;
    logic                  rd_chipselect;
    logic                  rd_write;
    logic [DATA_W-1:0]     rd_writedata;
    logic [DATA_W/8-1:0]   rd_byteenable;
    logic [DATA_W-1:0]     rd_readdata;
    logic                  rd_readdatavalid;
    logic                  rd_done;
    logic                  overflow;
    logic                  ovf_clear;

    modport master (
        output wr_valid, wr_data, wr_byteenable,
        output rd_address, rd_chipselect, rd_write, rd_writedata, rd_byteenable, rd_done,
        output ovf_clear,
        input  wr_ready, frame_ready, rd_bank, rd_readdata, rd_readdatavalid, overflow
    );

    modport slave (
        input  wr_valid, wr_data, wr_byteenable,
        input  rd_address, rd_chipselect, rd_write, rd_writedata, rd_byteenable, rd_done,
        input  ovf_clear,
        output wr_ready, frame_ready, rd_bank, rd_readdata, rd_readdatavalid, overflow
    );
endinterface

// File: rtl/fft_pingpong_ram.sv
// Purpose : two-bank ping-pong frame buffer; producer fills one bank while the FFT engine owns the other.
// Latency : engine reads return READ_LATENCY cycles after the strobe; frame_ready rises one cycle after a bank fills.
// Backpressure: wr_ready drops only when both banks are FULL/PROCESSING; a word offered then is dropped and sets overflow.
// Ports: clk_50mhz_clk (clock), reset_reset_n (async active-low reset), bus (slave side of fft_pingpong_ram_if).
module fft_pingpong_ram #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 11,
    parameter int READ_LATENCY = 1,
    parameter int BITREV_WR    = 0
) (
    input  logic               clk_50mhz_clk,
    input  logic               reset_reset_n,
    fft_pingpong_ram_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, PROCESSING} bank_state_t;

    bank_state_t         state [2];
    logic                wr_bank;
    logic [ADDR_W-1:0]   wr_cnt;
    logic                take_bank;       // next bank to hand to the engine (fill order)
    logic                rd_bank_q;
    logic                frame_ready_q;   // high exactly while a bank is PROCESSING
    logic                overflow_q;

    logic [DATA_W-1:0]   mem [2*DEPTH];
    logic [DATA_W-1:0]   pipe_dat [READ_LATENCY];
    logic                pipe_vld [READ_LATENCY];

    logic                wr_accept;
    logic                last_word;
    logic                eng_rd;
    logic                eng_wr;
    logic                release_bank;
    logic                take;
    logic [ADDR_W-1:0]   wr_addr;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
        return r;
    endfunction

    assign bus.wr_ready  = (state[wr_bank] == EMPTY) || (state[wr_bank] == FILLING);
    assign wr_accept     = bus.wr_valid & bus.wr_ready;
    assign last_word     = wr_accept & (&wr_cnt);
    assign wr_addr       = (BITREV_WR != 0) ? bitrev(wr_cnt) : wr_cnt;

    assign eng_rd        = bus.rd_chipselect & ~bus.rd_write & frame_ready_q;
    assign eng_wr        = bus.rd_chipselect &  bus.rd_write & frame_ready_q;
    assign release_bank  = bus.rd_done & frame_ready_q;
    // The engine is idle in the cycle after a release, so a waiting FULL bank is
    // taken one cycle later; that is the single-cycle frame_ready gap.
    assign take          = ~frame_ready_q && (state[take_bank] == FULL);

    assign bus.frame_ready      = frame_ready_q;
    assign bus.rd_bank          = rd_bank_q;
    assign bus.overflow         = overflow_q;
    assign bus.rd_readdata      = pipe_dat[READ_LATENCY-1];
    assign bus.rd_readdatavalid = pipe_vld[READ_LATENCY-1];

    always_ff @(posedge clk_50mhz_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state[0]      <= EMPTY;
            state[1]      <= EMPTY;
            wr_bank       <= 1'b0;
            wr_cnt        <= '0;
            take_bank     <= 1'b0;
            rd_bank_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_cnt <= wr_cnt + ADDR_W'(1);
                if (last_word) begin
                    state[wr_bank] <= FULL;
                    wr_bank        <= ~wr_bank;
                end else begin
                    state[wr_bank] <= FILLING;
                end
            end
            // Release and take never coincide: take needs frame_ready_q low,
            // release needs it high. Neither touches the producer's bank.
            if (release_bank) begin
                state[rd_bank_q] <= EMPTY;
                frame_ready_q    <= 1'b0;
            end
            if (take) begin
                state[take_bank] <= PROCESSING;
                rd_bank_q        <= take_bank;
                take_bank        <= ~take_bank;
                frame_ready_q    <= 1'b1;
            end
            // A new overflow event wins over a simultaneous clear.
            if (bus.wr_valid & ~bus.wr_ready)
                overflow_q <= 1'b1;
            else if (bus.ovf_clear)
                overflow_q <= 1'b0;
        end
    end

    // Array is deliberately not reset; producer and engine always hit different banks.
    always_ff @(posedge clk_50mhz_clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (wr_accept && bus.wr_byteenable[b])
                mem[{wr_bank, wr_addr}][8*b +: 8] <= bus.wr_data[8*b +: 8];
            if (eng_wr && bus.rd_byteenable[b])
                mem[{rd_bank_q, bus.rd_address}][8*b +: 8] <= bus.rd_writedata[8*b +: 8];
        end
    end

    always_ff @(posedge clk_50mhz_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= eng_rd;
            if (eng_rd)
                pipe_dat[0] <= mem[{rd_bank_q, bus.rd_address}];
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end
endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Purpose : randomized scoreboard bench for fft_pingpong_ram (natural-order large instance, bit-reversed small instance).
// Latency : read returns are checked against issue cycle + READ_LATENCY.
// Backpressure: producer holds wr_valid until wr_ready; stalls during a fill are counted as errors.
module tb_fft_pingpong_ram;
    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int DEPTH = 1 << AW;
    localparam int RL_A  = 1;
    localparam int AW_B  = 3;
    localparam int RL_B  = 2;

    logic clk = 1'b0;
    logic rst_a_n = 1'b1;
    logic rst_b_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fft_pingpong_ram_if #(.DATA_W(DW), .ADDR_W(AW))   bus_a ();
    fft_pingpong_ram_if #(.DATA_W(DW), .ADDR_W(AW_B)) bus_b ();

    fft_pingpong_ram #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(RL_A), .BITREV_WR(0)) dut_a (
        .clk_50mhz_clk (clk),
        .reset_reset_n (rst_a_n),
        .bus           (bus_a)
    );

    fft_pingpong_ram #(.DATA_W(DW), .ADDR_W(AW_B), .READ_LATENCY(RL_B), .BITREV_WR(1)) dut_b (
        .clk_50mhz_clk (clk),
        .reset_reset_n (rst_b_n),
        .bus           (bus_b)
    );

    typedef struct {
        logic [DW-1:0] dat;
        int            at;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    // Reference contents per bank, maintained from what the bench writes.
    logic [DW-1:0] ref_a [2][DEPTH];
    int            eng_bank = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n, input logic [3:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic int rev3(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 3; i++) if (k[i]) r = r | (1 << (2 - i));
        return r;
    endfunction

    // Scoreboard monitors: sample on the falling edge.
    always @(negedge clk) begin
        if (bus_a.rd_readdatavalid === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_valid: got readdatavalid=1 data=%0h, expected no read (t=%0t)", bus_a.rd_readdata, $time);
            end else begin
                ea = q_a.pop_front();
                check("a_rd_data", bus_a.rd_readdata, ea.dat);
                check("a_rd_latency", cyc, ea.at);
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.rd_readdatavalid === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_valid: got readdatavalid=1 data=%0h, expected no read (t=%0t)", bus_b.rd_readdata, $time);
            end else begin
                eb = q_b.pop_front();
                check("b_rd_data", bus_b.rd_readdata, eb.dat);
                check("b_rd_latency", cyc, eb.at);
            end
        end
    end

    task automatic idle_a();
        bus_a.wr_valid = 0; bus_a.wr_data = '0; bus_a.wr_byteenable = '0;
        bus_a.rd_address = '0; bus_a.rd_chipselect = 0; bus_a.rd_write = 0;
        bus_a.rd_writedata = '0; bus_a.rd_byteenable = '0; bus_a.rd_done = 0; bus_a.ovf_clear = 0;
    endtask

    task automatic idle_b();
        bus_b.wr_valid = 0; bus_b.wr_data = '0; bus_b.wr_byteenable = '0;
        bus_b.rd_address = '0; bus_b.rd_chipselect = 0; bus_b.rd_write = 0;
        bus_b.rd_writedata = '0; bus_b.rd_byteenable = '0; bus_b.rd_done = 0; bus_b.ovf_clear = 0;
    endtask

    // Stream words 0..n-1 of a frame into the bank the model expects.
    task automatic stream_a(input int bank, input int n, input bit rnd, input logic [DW-1:0] base);
        int stalls;
        logic [DW-1:0] d;
        logic [3:0] be;
        stalls = 0;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus_a.wr_valid = 0;
                tick();
            end
            d  = rnd ? DW'($urandom()) : base + DW'(k);
            be = rnd ? 4'($urandom_range(0, 15)) : 4'hf;
            if (rnd && k == 7) be = 4'b0001;
            bus_a.wr_valid = 1; bus_a.wr_data = d; bus_a.wr_byteenable = be;
            for (int t = 0; t < 20 && bus_a.wr_ready !== 1'b1; t++) begin
                stalls++;
                tick();
            end
            tick();
            ref_a[bank][k] = merge(ref_a[bank][k], d, be);
        end
        bus_a.wr_valid = 0;
        check("a_fill_no_stall", stalls, 0);
    endtask

    task automatic rd_a(input int addr);
        exp_t e;
        bus_a.rd_chipselect = 1; bus_a.rd_write = 0; bus_a.rd_address = AW'(addr);
        e.dat = ref_a[eng_bank][addr];
        e.at  = cyc + RL_A;
        q_a.push_back(e);
        tick();
        bus_a.rd_chipselect = 0;
    endtask

    task automatic wr_eng_a(input int addr, input logic [DW-1:0] d, input logic [3:0] be);
        bus_a.rd_chipselect = 1; bus_a.rd_write = 1; bus_a.rd_address = AW'(addr);
        bus_a.rd_writedata = d; bus_a.rd_byteenable = be;
        ref_a[eng_bank][addr] = merge(ref_a[eng_bank][addr], d, be);
        tick();
        bus_a.rd_chipselect = 0; bus_a.rd_write = 0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && (q_a.size() != 0 || q_b.size() != 0); t++) tick();
        check("a_drain_pending", q_a.size(), 0);
        check("b_drain_pending", q_b.size(), 0);
    endtask

    initial begin
        exp_t e;
        logic [DW-1:0] d;
        logic [3:0] be;
        int r;

        idle_a();
        idle_b();
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < DEPTH; k++) ref_a[b][k] = '0;
        #2;
        rst_a_n = 0;
        rst_b_n = 0;
        repeat (3) tick();

        check("rst_wr_ready", bus_a.wr_ready, 1);
        check("rst_frame_ready", bus_a.frame_ready, 0);
        check("rst_rd_bank", bus_a.rd_bank, 0);
        check("rst_rd_valid", bus_a.rd_readdatavalid, 0);
        check("rst_rd_data", bus_a.rd_readdata, 0);
        check("rst_overflow", bus_a.overflow, 0);
        rst_a_n = 1;
        rst_b_n = 1;
        tick();

        // Small instance: bit-reversed write order, two-cycle read latency.
        check("b_wr_ready", bus_b.wr_ready, 1);
        for (int k = 0; k < 8; k++) begin
            bus_b.wr_valid = 1; bus_b.wr_data = DW'(k); bus_b.wr_byteenable = 4'hf;
            tick();
        end
        bus_b.wr_valid = 0;
        check("b_frame_ready_at_full", bus_b.frame_ready, 0);
        tick();
        check("b_frame_ready", bus_b.frame_ready, 1);
        for (int i = 0; i < 11; i++) begin
            r = (i == 0) ? 1 : (i == 1) ? 3 : (i == 2) ? 6 : i - 3;
            bus_b.rd_chipselect = 1; bus_b.rd_write = 0; bus_b.rd_address = AW_B'(r);
            e.dat = DW'(rev3(r));
            e.at  = cyc + RL_B;
            q_b.push_back(e);
            tick();
        end
        bus_b.rd_chipselect = 0;

        // Frame 1 -> bank 0, natural data.
        stream_a(0, DEPTH, 0, 32'h0);
        check("a_frame_ready_at_full", bus_a.frame_ready, 0);
        tick();
        check("a_frame_ready_f1", bus_a.frame_ready, 1);
        check("a_rd_bank_f1", bus_a.rd_bank, 0);
        eng_bank = 0;
        rd_a(5);
        for (int i = 0; i < 10; i++) rd_a($urandom_range(0, DEPTH - 1));
        wr_eng_a(10, 32'hDEADBEEF, 4'b0011);
        rd_a(10);
        check("a_inplace_model", ref_a[0][10], 32'h0000BEEF);

        // Frame 2 -> bank 1 while bank 0 still owned: producer then blocks.
        stream_a(1, DEPTH, 0, 32'd2048);
        check("a_wr_ready_both_busy", bus_a.wr_ready, 0);
        check("a_frame_ready_both_busy", bus_a.frame_ready, 1);
        check("a_rd_bank_both_busy", bus_a.rd_bank, 0);
        bus_a.wr_valid = 1; bus_a.wr_data = 32'hBAD0BAD0; bus_a.wr_byteenable = 4'hf;
        tick();
        bus_a.wr_valid = 0;
        check("a_overflow_set", bus_a.overflow, 1);
        bus_a.wr_valid = 1; bus_a.ovf_clear = 1;
        tick();
        bus_a.wr_valid = 0;
        check("a_overflow_clear_vs_set", bus_a.overflow, 1);
        tick();
        bus_a.ovf_clear = 0;
        check("a_overflow_cleared", bus_a.overflow, 0);
        rd_a(0);

        // Release bank 0; ignored read during the one-cycle gap.
        bus_a.rd_done = 1;
        tick();
        bus_a.rd_done = 0;
        check("a_frame_ready_gap", bus_a.frame_ready, 0);
        check("a_wr_ready_after_release", bus_a.wr_ready, 1);
        bus_a.rd_chipselect = 1; bus_a.rd_write = 0; bus_a.rd_address = AW'(3);
        tick();
        bus_a.rd_chipselect = 0;
        check("a_frame_ready_f2", bus_a.frame_ready, 1);
        check("a_rd_bank_f2", bus_a.rd_bank, 1);
        eng_bank = 1;
        rd_a(0);
        for (int i = 0; i < 8; i++) rd_a($urandom_range(0, DEPTH - 1));

        // Frame 3 -> bank 0; last word coincides with rd_done and a read.
        stream_a(0, DEPTH - 1, 1, 32'h0);
        d  = $urandom();
        be = 4'($urandom_range(1, 15));
        r  = $urandom_range(0, DEPTH - 1);
        bus_a.wr_valid = 1; bus_a.wr_data = d; bus_a.wr_byteenable = be;
        bus_a.rd_done = 1;
        bus_a.rd_chipselect = 1; bus_a.rd_write = 0; bus_a.rd_address = AW'(r);
        e.dat = ref_a[1][r];
        e.at  = cyc + RL_A;
        q_a.push_back(e);
        check("a_wr_ready_last_word", bus_a.wr_ready, 1);
        ref_a[0][DEPTH-1] = merge(ref_a[0][DEPTH-1], d, be);
        tick();
        idle_a();
        check("a_wr_ready_swap", bus_a.wr_ready, 1);
        check("a_frame_ready_swap_gap", bus_a.frame_ready, 0);
        tick();
        check("a_frame_ready_f3", bus_a.frame_ready, 1);
        check("a_rd_bank_f3", bus_a.rd_bank, 0);
        check("a_wr_ready_f3", bus_a.wr_ready, 1);
        eng_bank = 0;
        rd_a(7);
        rd_a(10);
        rd_a(DEPTH - 1);
        for (int i = 0; i < 16; i++) rd_a($urandom_range(0, DEPTH - 1));
        drain();

        // Partial frame -> bank 1, then reset with a read in flight.
        stream_a(1, 700, 0, 32'h10000);
        bus_a.rd_chipselect = 1; bus_a.rd_write = 0; bus_a.rd_address = AW'($urandom_range(0, DEPTH - 1));
        tick();
        bus_a.rd_chipselect = 0;
        check("a_valid_before_reset", bus_a.rd_readdatavalid, 1);
        rst_a_n = 0;
        #1;
        check("a_reset_valid_drop", bus_a.rd_readdatavalid, 0);
        check("a_reset_rd_data", bus_a.rd_readdata, 0);
        check("a_reset_frame_ready", bus_a.frame_ready, 0);
        check("a_reset_wr_ready", bus_a.wr_ready, 1);
        check("a_reset_rd_bank", bus_a.rd_bank, 0);
        tick();
        tick();
        rst_a_n = 1;
        tick();
        check("a_wr_ready_after_reset", bus_a.wr_ready, 1);

        // Engine accesses and rd_done with no owned bank must be ignored.
        bus_a.rd_chipselect = 1; bus_a.rd_write = 1; bus_a.rd_address = AW'(7);
        bus_a.rd_writedata = 32'hFFFFFFFF; bus_a.rd_byteenable = 4'hf;
        tick();
        bus_a.rd_write = 0;
        tick();
        bus_a.rd_chipselect = 0;
        bus_a.rd_done = 1;
        tick();
        bus_a.rd_done = 0;
        check("a_frame_ready_ignored", bus_a.frame_ready, 0);

        // Fresh frame must land in bank 0 from address 0.
        stream_a(0, DEPTH, 1, 32'h0);
        tick();
        check("a_frame_ready_f4", bus_a.frame_ready, 1);
        check("a_rd_bank_f4", bus_a.rd_bank, 0);
        eng_bank = 0;
        rd_a(0);
        rd_a(7);
        rd_a(DEPTH - 1);
        for (int i = 0; i < 8; i++) rd_a($urandom_range(0, DEPTH - 1));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
